duty_cycle_scheduler: RTL and testbench
=======================================

DUTY_CYCLE_SCHEDULER -- requirements
Module: duty_cycle_scheduler

Interface
REQ-001 Parameter SETTLE, default 4: cycles a ring is enabled before its window opens; legal range 2..15.
REQ-002 Parameter WIN_BITS, default 8: window length 2^WIN_BITS clk cycles; result width 8 bits regardless.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  one-cycle request to begin a sweep; sampled only in IDLE.
REQ-006 abort  input  1  terminates the sweep in progress.
REQ-007 cont  input  1  continuous mode; sampled every STORE.
REQ-008 ring_mask  input  4  rings to measure; latched at accepted start.
REQ-009 ring_in  input  4  raw ring-oscillator outputs, asynchronous to clk.
REQ-010 ring_en  output  4  one-hot-or-zero enable to the ring oscillators.
REQ-011 busy  output  1  high from the cycle after accepted start until DONE or abort.
REQ-012 result_valid  output  1  one-cycle pulse per completed measurement.
REQ-013 result_idx  output  2  ring index of the current result.
REQ-014 result_duty  output  8  high-sample count of the current result.
REQ-015 done  output  1  one-cycle pulse at sweep end.

Function
REQ-016 The FSM SHALL have states IDLE, SETTLE, MEASURE, STORE, DONE.
REQ-017 ring_in SHALL pass through a 2-flop synchronizer per bit; measurement uses only synchronized bits.
REQ-018 IDLE: start=1 with ring_mask!=0 SHALL latch the mask, set idx = lowest set bit, clear counters, and enter SETTLE.
REQ-019 IDLE: start=1 with ring_mask=0 SHALL pulse done the next cycle, keep busy=0, and emit no result_valid.
REQ-020 SETTLE: ring_en SHALL equal one-hot(idx) for exactly SETTLE cycles, then enter MEASURE.
REQ-021 MEASURE: ring_en SHALL stay one-hot(idx) for exactly 2^WIN_BITS cycles; a 9-bit hi_cnt SHALL increment on each cycle in which synchronized ring_in[idx]=1.
REQ-022 STORE (one cycle): ring_en SHALL be 0; result_valid=1; result_idx=idx; result_duty = 255 if hi_cnt>=256 else hi_cnt[7:0] (saturation, no wrap).
REQ-023 Leaving STORE: next higher set bit of latched mask -> SETTLE with that idx; none and cont=1 -> SETTLE with lowest set bit; none and cont=0 -> DONE.
REQ-024 DONE SHALL pulse done for one cycle, clear busy, and return to IDLE.
REQ-025 With default parameters, result_valid SHALL assert exactly 261 cycles after start is sampled (1 + SETTLE + 256), and every 261 cycles thereafter for subsequent rings.
REQ-026 result_idx/result_duty SHALL hold their value until the next STORE.
REQ-027 start outside IDLE SHALL be ignored; changes to ring_mask after latching SHALL have no effect on the sweep.
REQ-028 abort in any non-IDLE state SHALL return to IDLE next cycle with ring_en=0, busy=0, and no result_valid or done; abort takes priority over STORE in the same cycle.
REQ-029 ring_en SHALL never have more than one bit set, and SHALL be 0 in IDLE, STORE, and DONE.

Reset
REQ-030 rst_n=0 SHALL immediately force IDLE, ring_en=0, busy=0, result_valid=0, done=0, result_idx=0, result_duty=0, synchronizers=0, and counters=0, including mid-sweep.
REQ-031 After rst_n release, the block SHALL accept start on the first rising edge.

Verification
REQ-032 ring_in=4'b0001 constant, mask=0001, start -> result_valid at cycle +261, idx=0, duty=255, done at +262, busy low at +262.
REQ-033 ring_in[2]=0, mask=0100 -> idx=2, duty=0; ring_en=0100 only during cycles +1..+260.
REQ-034 ring_in[1] toggling every clk, mask=0010 -> duty=128.
REQ-035 mask=1010, cont=0 -> results idx=1 then idx=3, 261 cycles apart; ring_en never multi-hot; single done pulse. With cont=1 -> idx sequence 1,3,1,3 until abort; abort gives no done pulse.
REQ-036 mask=0 start -> done pulse next cycle, no result_valid, busy=0.
REQ-037 rst_n low at MEASURE cycle 100 -> all outputs 0 at once; a new start completes normally with correct duty.

Source files
------------

// File: rtl/duty_cycle_scheduler.sv
// Sweeps up to four ring oscillators and measures each one's duty over a fixed window.
// One ring is enabled at a time: it settles first, then its synchronized output is sampled.
module duty_cycle_scheduler #(
    parameter int SETTLE   = 4,
    parameter int WIN_BITS = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    input  logic       cont,
    input  logic [3:0] ring_mask,
    input  logic [3:0] ring_in,
    output logic [3:0] ring_en,
    output logic       busy,
    output logic       result_valid,
    output logic [1:0] result_idx,
    output logic [7:0] result_duty,
    output logic       done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_MEASURE,
        S_STORE,
        S_DONE
    } state_t;

    state_t              state_q;
    logic [3:0]          mask_q;
    logic [1:0]          idx_q;
    logic [3:0]          settle_cnt_q;
    logic [WIN_BITS-1:0] win_cnt_q;
    logic [8:0]          hi_cnt_q;
    logic [3:0]          sync1_q;
    logic [3:0]          sync2_q;
    logic [3:0]          ring_en_q;
    logic                busy_q;
    logic                result_valid_q;
    logic [1:0]          result_idx_q;
    logic [7:0]          result_duty_q;
    logic                done_q;

    logic [1:0] first_idx_d;
    logic [1:0] low_idx_d;
    logic [1:0] next_idx_d;
    logic       has_next_d;
    logic       ring_bit_d;

    // Descending loops let the lowest qualifying bit win.
    always_comb begin
        first_idx_d = 2'd0;
        low_idx_d   = 2'd0;
        next_idx_d  = 2'd0;
        has_next_d  = 1'b0;
        for (int i = 3; i >= 0; i--) begin
            if (ring_mask[i]) first_idx_d = 2'(i);
            if (mask_q[i]) low_idx_d = 2'(i);
            if (mask_q[i] && (i > int'(idx_q))) begin
                next_idx_d = 2'(i);
                has_next_d = 1'b1;
            end
        end
        ring_bit_d = sync2_q[idx_q];
    end

    // Outputs are registered from the current state, so they lag the state by one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            mask_q         <= 4'd0;
            idx_q          <= 2'd0;
            settle_cnt_q   <= 4'd0;
            win_cnt_q      <= '0;
            hi_cnt_q       <= 9'd0;
            sync1_q        <= 4'd0;
            sync2_q        <= 4'd0;
            ring_en_q      <= 4'd0;
            busy_q         <= 1'b0;
            result_valid_q <= 1'b0;
            result_idx_q   <= 2'd0;
            result_duty_q  <= 8'd0;
            done_q         <= 1'b0;
        end else begin
            sync1_q        <= ring_in;
            sync2_q        <= sync1_q;
            result_valid_q <= 1'b0;
            done_q         <= 1'b0;
            if (abort && (state_q != S_IDLE)) begin
                state_q   <= S_IDLE;
                ring_en_q <= 4'd0;
                busy_q    <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        ring_en_q <= 4'd0;
                        if (start) begin
                            if (|ring_mask) begin
                                mask_q       <= ring_mask;
                                idx_q        <= first_idx_d;
                                settle_cnt_q <= 4'd0;
                                win_cnt_q    <= '0;
                                hi_cnt_q     <= 9'd0;
                                busy_q       <= 1'b1;
                                state_q      <= S_SETTLE;
                            end else begin
                                state_q <= S_DONE;
                            end
                        end
                    end
                    S_SETTLE: begin
                        ring_en_q <= 4'b0001 << idx_q;
                        if (settle_cnt_q == 4'(SETTLE - 1)) begin
                            settle_cnt_q <= 4'd0;
                            state_q      <= S_MEASURE;
                        end else begin
                            settle_cnt_q <= settle_cnt_q + 4'd1;
                        end
                    end
                    S_MEASURE: begin
                        ring_en_q <= 4'b0001 << idx_q;
                        if (ring_bit_d && !hi_cnt_q[8]) hi_cnt_q <= hi_cnt_q + 9'd1;
                        win_cnt_q <= win_cnt_q + 1'b1;
                        if (win_cnt_q == '1) state_q <= S_STORE;
                    end
                    S_STORE: begin
                        ring_en_q      <= 4'd0;
                        result_valid_q <= 1'b1;
                        result_idx_q   <= idx_q;
                        result_duty_q  <= hi_cnt_q[8] ? 8'hFF : hi_cnt_q[7:0];
                        hi_cnt_q       <= 9'd0;
                        if (has_next_d) begin
                            idx_q   <= next_idx_d;
                            state_q <= S_SETTLE;
                        end else if (cont) begin
                            idx_q   <= low_idx_d;
                            state_q <= S_SETTLE;
                        end else begin
                            state_q <= S_DONE;
                        end
                    end
                    S_DONE: begin
                        ring_en_q <= 4'd0;
                        done_q    <= 1'b1;
                        busy_q    <= 1'b0;
                        state_q   <= S_IDLE;
                    end
                    default: begin
                        ring_en_q <= 4'd0;
                        state_q   <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign ring_en      = ring_en_q;
    assign busy         = busy_q;
    assign result_valid = result_valid_q;
    assign result_idx   = result_idx_q;
    assign result_duty  = result_duty_q;
    assign done         = done_q;

endmodule

// File: tb/tb_duty_cycle_scheduler.sv
// Directed bench for duty_cycle_scheduler: expected {idx,duty} results queue up at each
// start and are popped as result_valid pulses appear; timing is checked relative to start.
module tb_duty_cycle_scheduler;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       abort;
    logic       cont;
    logic [3:0] ring_mask;
    logic [3:0] ring_in;
    logic [3:0] ring_en;
    logic       busy;
    logic       result_valid;
    logic [1:0] result_idx;
    logic [7:0] result_duty;
    logic       done;

    duty_cycle_scheduler dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .abort        (abort),
        .cont         (cont),
        .ring_mask    (ring_mask),
        .ring_in      (ring_in),
        .ring_en      (ring_en),
        .busy         (busy),
        .result_valid (result_valid),
        .result_idx   (result_idx),
        .result_duty  (result_duty),
        .done         (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks;
    int failures;
    int cyc;
    int t0;
    int n_valid;
    int n_done;
    int last_valid;
    int last_done;
    int en_first;
    int en_last;
    logic [3:0] en_or;
    logic       multihot;
    logic       toggle1;
    logic [9:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic clear_stats();
        n_valid    = 0;
        n_done     = 0;
        last_valid = -1;
        last_done  = -1;
        en_first   = -1;
        en_last    = -1;
        en_or      = 4'd0;
        multihot   = 1'b0;
    endtask

    task automatic do_start(input logic [3:0] mask);
        clear_stats();
        start     = 1'b1;
        ring_mask = mask;
        tick();
        start = 1'b0;
        t0    = cyc;
    endtask

    task automatic run(input int n);
        logic [9:0] e;
        for (int k = 0; k < n; k++) begin
            tick();
            if (toggle1) ring_in[1] = ~ring_in[1];
            if ((ring_en & (ring_en - 4'd1)) != 4'd0) multihot = 1'b1;
            if (ring_en != 4'd0) begin
                if (en_first < 0) en_first = cyc - t0;
                en_last = cyc - t0;
                en_or   = en_or | ring_en;
            end
            if (result_valid) begin
                n_valid++;
                last_valid = cyc - t0;
                if (exp_q.size() == 0) begin
                    check("unexpected_result_valid", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("result_idx", 32'(result_idx), 32'(e[9:8]));
                    check("result_duty", 32'(result_duty), 32'(e[7:0]));
                end
            end
            if (done) begin
                n_done++;
                last_done = cyc - t0;
            end
        end
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        cyc       = 0;
        t0        = 0;
        toggle1   = 1'b0;
        rst_n     = 1'b0;
        start     = 1'b0;
        abort     = 1'b0;
        cont      = 1'b0;
        ring_mask = 4'd0;
        ring_in   = 4'd0;
        clear_stats();
        tick();
        tick();
        check("rst_ring_en", 32'(ring_en), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_valid", 32'(result_valid), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_idx", 32'(result_idx), 32'd0);
        check("rst_duty", 32'(result_duty), 32'd0);
        rst_n = 1'b1;

        // Single ring held high saturates at 255; start taken on the first edge after reset.
        ring_in = 4'b0001;
        exp_q.push_back({2'd0, 8'd255});
        do_start(4'b0001);
        check("a_busy_after_start", 32'(busy), 32'd1);
        run(260);
        check("a_no_valid_before_261", 32'(n_valid), 32'd0);
        run(1);
        check("a_valid_cycle", 32'(last_valid), 32'd261);
        check("a_ring_en_store", 32'(ring_en), 32'd0);
        run(1);
        check("a_done_cycle", 32'(last_done), 32'd262);
        check("a_busy_low", 32'(busy), 32'd0);
        run(3);
        check("a_done_count", 32'(n_done), 32'd1);
        check("a_en_first", 32'(en_first), 32'd1);
        check("a_en_last", 32'(en_last), 32'd260);

        // Ring 2 held low while its neighbours are high.
        ring_in = 4'b1011;
        exp_q.push_back({2'd2, 8'd0});
        do_start(4'b0100);
        run(265);
        check("b_valid_cycle", 32'(last_valid), 32'd261);
        check("b_en_or", 32'(en_or), 32'h4);
        check("b_en_first", 32'(en_first), 32'd1);
        check("b_en_last", 32'(en_last), 32'd260);

        // Ring 1 toggles every clock: half the window samples high.
        ring_in = 4'b0000;
        toggle1 = 1'b1;
        exp_q.push_back({2'd1, 8'd128});
        do_start(4'b0010);
        run(265);
        toggle1 = 1'b0;
        check("c_valid_count", 32'(n_valid), 32'd1);

        // Two-ring sweep; start and mask changes mid-sweep must be ignored.
        ring_in = 4'b1000;
        cont    = 1'b0;
        exp_q.push_back({2'd1, 8'd0});
        exp_q.push_back({2'd3, 8'd255});
        do_start(4'b1010);
        run(50);
        start     = 1'b1;
        ring_mask = 4'b0001;
        run(1);
        start = 1'b0;
        run(210);
        check("d_first_valid", 32'(last_valid), 32'd261);
        run(261);
        check("d_second_valid", 32'(last_valid), 32'd522);
        run(4);
        check("d_valid_count", 32'(n_valid), 32'd2);
        check("d_done_cycle", 32'(last_done), 32'd523);
        check("d_done_count", 32'(n_done), 32'd1);
        check("d_multihot", 32'(multihot), 32'd0);
        check("d_en_or", 32'(en_or), 32'ha);

        // Continuous mode wraps back to the lowest ring until aborted.
        ring_in = 4'b1010;
        cont    = 1'b1;
        for (int i = 0; i < 4; i++) exp_q.push_back({(i % 2 == 0) ? 2'd1 : 2'd3, 8'd255});
        do_start(4'b1010);
        run(1044);
        check("e_valid_count", 32'(n_valid), 32'd4);
        check("e_last_valid", 32'(last_valid), 32'd1044);
        abort = 1'b1;
        run(1);
        abort = 1'b0;
        check("e_abort_busy", 32'(busy), 32'd0);
        check("e_abort_ring_en", 32'(ring_en), 32'd0);
        run(5);
        check("e_no_done", 32'(n_done), 32'd0);
        check("e_multihot", 32'(multihot), 32'd0);
        check("e_queue_empty", 32'(exp_q.size()), 32'd0);
        cont = 1'b0;

        // Empty mask completes immediately.
        do_start(4'b0000);
        check("f_busy", 32'(busy), 32'd0);
        run(1);
        check("f_done", 32'(done), 32'd1);
        run(3);
        check("f_done_count", 32'(n_done), 32'd1);
        check("f_no_valid", 32'(n_valid), 32'd0);

        // Abort landing on the store cycle suppresses the result.
        ring_in = 4'b0001;
        do_start(4'b0001);
        run(260);
        abort = 1'b1;
        run(1);
        abort = 1'b0;
        run(4);
        check("g_no_valid", 32'(n_valid), 32'd0);
        check("g_no_done", 32'(n_done), 32'd0);
        check("g_busy", 32'(busy), 32'd0);

        // Reset at measure cycle 100, then a clean sweep.
        do_start(4'b0001);
        run(104);
        rst_n = 1'b0;
        #1;
        check("h_rst_ring_en", 32'(ring_en), 32'd0);
        check("h_rst_busy", 32'(busy), 32'd0);
        check("h_rst_valid", 32'(result_valid), 32'd0);
        check("h_rst_done", 32'(done), 32'd0);
        check("h_rst_idx", 32'(result_idx), 32'd0);
        check("h_rst_duty", 32'(result_duty), 32'd0);
        tick();
        rst_n   = 1'b1;
        ring_in = 4'b0000;
        toggle1 = 1'b1;
        exp_q.push_back({2'd1, 8'd128});
        do_start(4'b0010);
        run(264);
        toggle1 = 1'b0;
        check("h_valid_cycle", 32'(last_valid), 32'd261);
        check("h_done_cycle", 32'(last_done), 32'd262);
        check("h_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
